clock_divider_ff: RTL and testbench

- Parameterised integer clock divider, fully registered (flip-flop based).
- Derives a low-rate clock, `clk_out`, from the system clock `clk`. Ratio is DIV = CLK_FREQ / OUT_FREQ.
- Used by the NCO to produce its sample clock.
- Also provides a single-cycle `tick` strobe in the `clk` domain, so consumers can use a clock enable instead of a derived clock.

---
 rtl/clock_divider_ff_pkg.sv | 18 +
 rtl/clock_divider_ff.sv | 58 +++++
 tb/tb_clock_divider_ff.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/clock_divider_ff_pkg.sv
// Shared helpers for rate-derived blocks (divider, NCO, and friends).
package clock_divider_ff_pkg;

  // Counter width for a modulus: ceil(log2(value)), never less than one bit.
  function automatic int clog2_min1(input int value);
    int r;
    r = $clog2(value);
    return (r < 1) ? 1 : r;
  endfunction

  // Integer division ratio between two frequencies.
  // A zero output frequency yields 0, which callers treat as illegal.
  function automatic int div_ratio(input int clk_freq, input int out_freq);
    if (out_freq <= 0) return 0;
    return clk_freq / out_freq;
  endfunction

endpackage

// File: rtl/clock_divider_ff.sv
// Fully registered integer clock divider.
// clk_out is low for LOW cycles, then high for HIGH cycles, giving one period
// every DIV cycles of clk. tick is a one-cycle strobe on the first high cycle,
// so consumers can run on clk with a clock enable.
module clock_divider_ff
  import clock_divider_ff_pkg::*;
#(
  parameter int CLK_FREQ = 50_000_000,
  parameter int OUT_FREQ = 48_000
) (
  input  logic clk,
  input  logic rst,
  output logic clk_out,
  output logic tick
);

  localparam int DIV  = div_ratio(CLK_FREQ, OUT_FREQ);
  localparam int LOW  = DIV / 2;
  localparam int HIGH = DIV - LOW;
  localparam int CW   = clog2_min1(DIV);

  localparam logic [CW-1:0] LAST_C = CW'(DIV - 1);
  localparam logic [CW-1:0] LOW_C  = CW'(LOW);

  // Reject configurations that cannot produce an output clock.
  if (OUT_FREQ == 0) begin : g_err_zero_out
    $error("clock_divider_ff: OUT_FREQ must be non-zero");
  end
  if (DIV == 0) begin : g_err_zero_div
    $error("clock_divider_ff: OUT_FREQ exceeds CLK_FREQ");
  end
  if (HIGH - LOW > 1) begin : g_err_phase
    $error("clock_divider_ff: phase split is inconsistent");
  end

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  // Modulo-DIV successor of the phase counter.
  always_comb begin
    count_next = (count == LAST_C) ? '0 : count + CW'(1);
  end

  // Phase counter plus output flops; both outputs are decoded from the
  // upcoming count so they land in the same cycle as the count they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      count   <= count_next;
      clk_out <= (count_next >= LOW_C);
      tick    <= (count_next == LOW_C);
    end
  end

endmodule

// File: tb/tb_clock_divider_ff.sv
// Bench for clock_divider_ff: four configurations share clk and rst.
module tb_clock_divider_ff;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic c5, t5, c4, t4, cd, td, c1, t1;

  clock_divider_ff #(.CLK_FREQ(10), .OUT_FREQ(2)) u_div5 (
    .clk(clk), .rst(rst), .clk_out(c5), .tick(t5));
  clock_divider_ff #(.CLK_FREQ(8), .OUT_FREQ(2)) u_div4 (
    .clk(clk), .rst(rst), .clk_out(c4), .tick(t4));
  clock_divider_ff u_def (
    .clk(clk), .rst(rst), .clk_out(cd), .tick(td));
  clock_divider_ff #(.CLK_FREQ(48_000), .OUT_FREQ(48_000)) u_div1 (
    .clk(clk), .rst(rst), .clk_out(c1), .tick(t1));

  // ---------------- scoreboard state ----------------
  logic [5:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int phase  = 0;   // edges since reset release
  int cyc    = 0;

  // Hand-written per-phase tables, index = (phase-1) mod DIV.
  bit clk5_tab[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  bit tick5_tab[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  bit clk4_tab[4]  = '{1'b0, 1'b1, 1'b1, 1'b0};
  bit tick4_tab[4] = '{1'b0, 1'b1, 1'b0, 1'b0};

  // Expected {c5,t5,c4,t4,c1,t1} after an edge.
  function automatic logic [5:0] expected(input bit in_rst, input int p);
    int q5;
    int q4;
    if (in_rst) return 6'b0;
    q5 = (p - 1) % 5;
    q4 = (p - 1) % 4;
    return {clk5_tab[q5], tick5_tab[q5], clk4_tab[q4], tick4_tab[q4], 1'b1, 1'b1};
  endfunction

  task automatic check(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, actual, required);
    end
  endtask

  // ---------------- driver ----------------
  // Drive rst for the next edge, then queue the response that edge produces.
  task automatic step(input bit r);
    rst = r;
    @(posedge clk);
    if (r) phase = 0;
    else phase++;
    exp_q.push_back(expected(r, phase));
    #1;
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [5:0] e;
    logic [5:0] act;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {c5, t5, c4, t4, c1, t1};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL cyc%0d {c5,t5,c4,t4,c1,t1}: got %b expected %b", cyc, act, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic prev;
    int rises;
    int n;
    int r1;
    int r2;
    int f1;
    int ticks_d;

    // Reset held for two edges, then the DIV=5 waveform from release.
    step(1'b1);
    step(1'b1);
    repeat (12) step(1'b0);

    // Abort a DIV=5 period while clk_out is high at count 3.
    while (phase % 5 != 3) step(1'b0);
    step(1'b1);
    repeat (12) step(1'b0);

    // DIV=4: any 400-edge window holds exactly 100 rises.
    rises = 0;
    prev  = c4;
    repeat (400) begin
      step(1'b0);
      if (c4 && !prev) rises++;
      prev = c4;
    end
    check("div4_rises_400", rises, 100);

    // Default DIV=1041: measure period and phase lengths.
    n = 0; r1 = -1; r2 = -1; f1 = -1; ticks_d = 0;
    prev = cd;
    while (n < 4000 && r2 < 0) begin
      step(1'b0);
      n++;
      if (r1 >= 0 && td) ticks_d++;
      if (cd && !prev) begin
        if (r1 < 0) begin
          r1 = n;
          if (td) ticks_d++;
        end else begin
          r2 = n;
        end
      end
      if (!cd && prev && r1 >= 0 && f1 < 0) f1 = n;
      prev = cd;
    end
    if (r2 < 0 || f1 < 0) begin
      checks++;
      errors++;
      $display("FAIL def_timeout: got r1=%0d f1=%0d r2=%0d expected two rises within 4000 edges", r1, f1, r2);
    end else begin
      check("def_period", r2 - r1, 1041);
      check("def_high", f1 - r1, 521);
      check("def_low", r2 - f1, 520);
      check("def_ticks", ticks_d, 2);
    end

    // Let the monitor drain the last queued response.
    @(posedge clk);
    #3;
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
